// File: rtl/mult_div_hilo_if.sv
// Request/result bundle between EX and the HI/LO multiply/divide unit.
// master drives i_Start/i_Op/i_RS/i_RT; slave drives o_HI/o_LO/o_Busy/o_Done.
interface mult_div_hilo_if #(
  parameter int NBITS  = 32,
  parameter int OPBITS = 3
);
  logic              i_Start;
  logic [OPBITS-1:0] i_Op;
  logic [NBITS-1:0]  i_RS;
  logic [NBITS-1:0]  i_RT;
  logic [NBITS-1:0]  o_HI;
  logic [NBITS-1:0]  o_LO;
  logic              o_Busy;
  logic              o_Done;

  modport master (
    output i_Start, i_Op, i_RS, i_RT,
    input  o_HI, o_LO, o_Busy, o_Done
  );

  modport slave (
    input  i_Start, i_Op, i_RS, i_RT,
    output o_HI, o_LO, o_Busy, o_Done
  );
endinterface

// File: rtl/mult_div_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO for the EX stage.
// Ports: clk, reset (async active-low), bus (mult_div_hilo_if.slave).
// Optional MULTDIV_FAST_MULT_EN: single-cycle array multiply (IDLE->FIX).
module mult_div_hilo #(
  parameter int NBITS  = 32,
  parameter int OPBITS = 3
) (
  input logic            clk,
  input logic            reset,
  mult_div_hilo_if.slave bus
);

  localparam int CW = $clog2(NBITS + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  localparam logic [OPBITS-1:0] OP_MULT  = OPBITS'(0);
  localparam logic [OPBITS-1:0] OP_MULTU = OPBITS'(1);
  localparam logic [OPBITS-1:0] OP_DIV   = OPBITS'(2);
  localparam logic [OPBITS-1:0] OP_DIVU  = OPBITS'(3);
  localparam logic [OPBITS-1:0] OP_MTHI  = OPBITS'(4);
  localparam logic [OPBITS-1:0] OP_MTLO  = OPBITS'(5);

  logic [1:0]       r_State;
  logic [CW-1:0]    r_Cnt;
  logic [NBITS-1:0] r_Acc;
  logic [NBITS-1:0] r_Q;
  logic [NBITS-1:0] r_M;
  logic             r_IsDiv;
  logic             r_NegA;
  logic             r_NegB;
  logic             r_DivZero;
  logic [NBITS-1:0] r_HI;
  logic [NBITS-1:0] r_LO;
  logic             r_Done;

  logic             w_Idle;
  logic             w_IsMult;
  logic             w_IsDiv;
  logic             w_Signed;
  logic             w_MtHi;
  logic             w_MtLo;
  logic             w_RsNeg;
  logic             w_RtNeg;
  logic [NBITS-1:0] w_RsMag;
  logic [NBITS-1:0] w_RtMag;

  logic [NBITS:0]   w_MulSum;
  logic [NBITS:0]   w_Shift;
  logic             w_Ge;
  logic [NBITS-1:0] w_Sub;

  logic [2*NBITS-1:0] w_Prod;
  logic [2*NBITS-1:0] w_ProdFix;
  logic [NBITS-1:0]   w_QuoFix;
  logic [NBITS-1:0]   w_RemFix;

  assign w_Idle = (r_State == S_IDLE);

  always_comb begin
    w_IsMult = 1'b0;
    w_IsDiv  = 1'b0;
    w_Signed = 1'b0;
    w_MtHi   = 1'b0;
    w_MtLo   = 1'b0;
    case (bus.i_Op)
      OP_MULT: begin
        w_IsMult = 1'b1;
        w_Signed = 1'b1;
      end
      OP_MULTU: w_IsMult = 1'b1;
      OP_DIV: begin
        w_IsDiv  = 1'b1;
        w_Signed = 1'b1;
      end
      OP_DIVU: w_IsDiv = 1'b1;
      OP_MTHI: w_MtHi = 1'b1;
      OP_MTLO: w_MtLo = 1'b1;
      default: ;
    endcase
  end

  assign w_RsNeg = w_Signed & bus.i_RS[NBITS-1];
  assign w_RtNeg = w_Signed & bus.i_RT[NBITS-1];
  assign w_RsMag = w_RsNeg ? -bus.i_RS : bus.i_RS;
  assign w_RtMag = w_RtNeg ? -bus.i_RT : bus.i_RT;

  // Multiply: {r_Acc,r_Q} shifts right; r_Q starts as multiplier.
  assign w_MulSum = {1'b0, r_Acc}
                  + (r_Q[0] ? {1'b0, r_M} : '0);

  // Divide: {r_Acc,r_Q} shifts left; r_Acc is the partial remainder.
  // A kept remainder is always below the divisor, so it fits NBITS.
  assign w_Shift = {r_Acc, r_Q[NBITS-1]};
  assign w_Ge    = (w_Shift >= {1'b0, r_M});
  assign w_Sub   = w_Shift[NBITS-1:0] - r_M;

  assign w_Prod    = {r_Acc, r_Q};
  assign w_ProdFix = (r_NegA ^ r_NegB) ? -w_Prod : w_Prod;
  assign w_QuoFix  = (r_NegA ^ r_NegB) ? -r_Q : r_Q;
  // By zero, the remainder ends up as the dividend magnitude,
  // so restoring its sign yields the original rs.
  assign w_RemFix  = r_NegA ? -r_Acc : r_Acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_State   <= S_IDLE;
      r_Cnt     <= '0;
      r_Acc     <= '0;
      r_Q       <= '0;
      r_M       <= '0;
      r_IsDiv   <= 1'b0;
      r_NegA    <= 1'b0;
      r_NegB    <= 1'b0;
      r_DivZero <= 1'b0;
      r_HI      <= '0;
      r_LO      <= '0;
      r_Done    <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (1'b1)
        (r_State == S_IDLE): begin
          if (bus.i_Start && (w_IsMult || w_IsDiv)) begin
            r_IsDiv   <= w_IsDiv;
            r_NegA    <= w_RsNeg;
            r_NegB    <= w_RtNeg;
            r_DivZero <= w_IsDiv && (bus.i_RT == '0);
            r_M       <= w_IsMult ? w_RsMag : w_RtMag;
            r_Cnt     <= CW'(NBITS);
`ifdef MULTDIV_FAST_MULT_EN
            if (w_IsMult) begin
              {r_Acc, r_Q} <= (2*NBITS)'(w_RsMag)
                            * (2*NBITS)'(w_RtMag);
              r_State <= S_FIX;
            end else begin
              r_Acc   <= '0;
              r_Q     <= w_RsMag;
              r_State <= S_CALC;
            end
`else
            r_Acc   <= '0;
            r_Q     <= w_IsMult ? w_RtMag : w_RsMag;
            r_State <= S_CALC;
`endif
          end else if (bus.i_Start && w_MtHi) begin
            r_HI <= bus.i_RS;
          end else if (bus.i_Start && w_MtLo) begin
            r_LO <= bus.i_RS;
          end
        end
        (r_State == S_CALC): begin
          if (r_IsDiv) begin
            r_Acc <= w_Ge ? w_Sub : w_Shift[NBITS-1:0];
            r_Q   <= {r_Q[NBITS-2:0], w_Ge};
          end else begin
            r_Acc <= w_MulSum[NBITS:1];
            r_Q   <= {w_MulSum[0], r_Q[NBITS-1:1]};
          end
          r_Cnt <= r_Cnt - 1'b1;
          if (r_Cnt == CW'(1)) r_State <= S_FIX;
        end
        (r_State == S_FIX): begin
          if (r_IsDiv) begin
            r_HI <= w_RemFix;
            r_LO <= r_DivZero ? '1 : w_QuoFix;
          end else begin
            {r_HI, r_LO} <= w_ProdFix;
          end
          r_Done  <= 1'b1;
          r_State <= S_IDLE;
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign bus.o_HI   = r_HI;
  assign bus.o_LO   = r_LO;
  assign bus.o_Busy = !w_Idle;
  assign bus.o_Done = r_Done;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Randomized check of mult_div_hilo against an arithmetic HI/LO model.
// Covers directed corner cases, busy-ignore and async reset mid-op.
module tb_mult_div_hilo;

`ifdef MULTDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_hilo_if #(.NBITS(32), .OPBITS(3)) bus ();

  mult_div_hilo #(.NBITS(32), .OPBITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] rs,
                                input logic [31:0] rt,
                                inout logic [31:0] hi,
                                inout logic [31:0] lo);
    int a;
    int b;
    longint p;
    logic [63:0] u;
    a = rs;
    b = rt;
    case (op)
      3'd0: begin
        p = longint'(a) * longint'(b);
        {hi, lo} = p;
      end
      3'd1: begin
        u = {32'd0, rs} * {32'd0, rt};
        {hi, lo} = u;
      end
      3'd2: begin
        if (rt == 0) begin
          lo = '1; hi = rs;
        end else if (rs == 32'h8000_0000 && rt == '1) begin
          lo = rs; hi = '0;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      3'd3: begin
        if (rt == 0) begin
          lo = '1; hi = rs;
        end else begin
          lo = rs / rt; hi = rs % rt;
        end
      end
      3'd4: hi = rs;
      3'd5: lo = rs;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (FAST && op <= 3'd1) ? 1 : 33;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Op    = op;
    bus.i_RS    = rs;
    bus.i_RT    = rt;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input string tag);
    logic [31:0] ehi;
    logic [31:0] elo;
    int lat;
    ehi = m_hi;
    elo = m_lo;
    model(op, rs, rt, ehi, elo);
    drive(op, rs, rt);
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    if (op <= 3'd3) begin
      chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd1);
      lat = 0;
      while (lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (bus.o_Done) break;
      end
      chk({tag, "_lat"}, lat, exp_lat(op));
      chk({tag, "_hi"}, bus.o_HI, ehi);
      chk({tag, "_lo"}, bus.o_LO, elo);
      @(posedge clk); #1;
      chk({tag, "_done1"}, 32'(bus.o_Done), 32'd0);
      chk({tag, "_idle"}, 32'(bus.o_Busy), 32'd0);
    end else begin
      chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.o_Done), 32'd0);
      chk({tag, "_hi"}, bus.o_HI, ehi);
      chk({tag, "_lo"}, bus.o_LO, elo);
    end
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic t_ignore();
    int lat;
    int inj;
    int pulses;
    inj = FAST ? 1 : 5;
    drive(3'd1, 32'd2, 32'd3);
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (lat + 1 == inj) drive(3'd3, 32'd9, 32'd3);
      @(posedge clk); #1;
      lat++;
      bus.i_Start = 1'b0;
`ifndef MULTDIV_FAST_MULT_EN
      if (lat == inj) begin
        chk("ign_hold_hi", bus.o_HI, m_hi);
        chk("ign_hold_lo", bus.o_LO, m_lo);
        chk("ign_busy", 32'(bus.o_Busy), 32'd1);
      end
`endif
      if (bus.o_Done) break;
    end
    chk("ign_lat", lat, exp_lat(3'd1));
    chk("ign_hi", bus.o_HI, 32'd0);
    chk("ign_lo", bus.o_LO, 32'd6);
    @(posedge clk); #1;
    chk("ign_idle", 32'(bus.o_Busy), 32'd0);
    pulses = 0;
    repeat (36) begin
      @(posedge clk); #1;
      if (bus.o_Done || bus.o_Busy) pulses++;
    end
    chk("ign_noqueue", pulses, 0);
    chk("ign_lo_after", bus.o_LO, 32'd6);
    m_hi = 32'd0;
    m_lo = 32'd6;
  endtask

  task automatic t_reset();
    drive(3'd2, 32'd1000, 32'd7);
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_hi", bus.o_HI, 32'd0);
    chk("rst_lo", bus.o_LO, 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_done", 32'(bus.o_Done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    do_op(3'd1, 32'd5, 32'd6, "rst_mulu");
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_rs;
  logic [31:0] r_rt;

  initial begin
    bus.i_Start = 1'b0;
    bus.i_Op    = '0;
    bus.i_RS    = '0;
    bus.i_RT    = '0;
    #1;
    chk("init_hi", bus.o_HI, 32'd0);
    chk("init_lo", bus.o_LO, 32'd0);
    chk("init_busy", 32'(bus.o_Busy), 32'd0);
    chk("init_done", 32'(bus.o_Done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mul_neg");
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mul_min");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(3'd3, 32'd7, 32'd0, "divu_z");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd0, "div_z");
    do_op(3'd4, 32'h1234, 32'd0, "mthi");
    do_op(3'd5, 32'h5678, 32'd0, "mtlo");
    do_op(3'd6, 32'hDEAD, 32'd0, "nop6");
    t_ignore();
    t_reset();

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: r_rs = 32'h8000_0000;
        1: r_rs = $urandom_range(0, 100);
        default: r_rs = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: r_rt = 32'd0;
        1: r_rt = 32'hFFFF_FFFF;
        2: r_rt = $urandom_range(1, 9);
        default: r_rt = $urandom;
      endcase
      do_op(r_op, r_rs, r_rt, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
